// File: rtl/sram_controller.sv
// Pipeline-facing controller for a 16-bit asynchronous SRAM: each 32-bit word is moved as two half-word cycles.
// Optional one-entry last-read register enabled by defining SRAM_READ_HIT_EN.
module sram_controller #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LO,
    ST_HI,
    ST_WAIT,
    ST_DONE
  } state_t;

  localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  wait_cnt;
  logic        op_write;
  logic [16:0] idx_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [31:0] addr_off;
  logic [16:0] req_idx;
  logic        req;
  logic        hit;
  logic        drive;
  logic        unused_addr;

  assign addr_off    = address - 32'd1024;
  assign req_idx     = addr_off[18:2];
  assign unused_addr = ^{addr_off[31:19], addr_off[1:0]};
  assign req         = wr_en | rd_en;

`ifdef SRAM_READ_HIT_EN
  logic        hit_valid;
  logic [16:0] hit_tag;
  logic [31:0] hit_data;

  assign hit       = (state == ST_IDLE) && rd_en && !wr_en && hit_valid && (hit_tag == req_idx);
  assign read_data = hit ? hit_data : rdata_q;

  // Entry follows the last completed read; a write to the cached word keeps it coherent.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hit_valid <= 1'b0;
      hit_tag   <= '0;
      hit_data  <= '0;
    end else if (state == ST_DONE) begin
      if (!op_write) begin
        hit_valid <= 1'b1;
        hit_tag   <= idx_q;
        hit_data  <= rdata_q;
      end else if (hit_valid && (hit_tag == idx_q)) begin
        hit_data  <= wdata_q;
      end
    end
  end
`else
  assign hit       = 1'b0;
  assign read_data = rdata_q;
`endif

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (hit) begin
          ready = 1'b1;
        end else if (req) begin
          state_nxt = ST_LO;
        end else begin
          ready = 1'b1;
        end
      end
      ST_LO:   state_nxt = ST_HI;
      ST_HI:   state_nxt = (WAIT_CYCLES == 0) ? ST_DONE : ST_WAIT;
      ST_WAIT: if (wait_cnt == WAIT_LAST) state_nxt = ST_DONE;
      ST_DONE: begin
        ready     = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      op_write <= 1'b0;
      idx_q    <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          // On a hit read_data already carries the cached word, so this keeps it held afterwards.
          if (hit) begin
            rdata_q <= read_data;
          end else if (req) begin
            op_write <= wr_en;
            idx_q    <= req_idx;
            wdata_q  <= write_data;
          end
        end
        ST_LO: if (!op_write) rdata_q[15:0] <= SRAM_DQ;
        ST_HI: begin
          if (!op_write) rdata_q[31:16] <= SRAM_DQ;
          wait_cnt <= '0;
        end
        ST_WAIT: wait_cnt <= wait_cnt + 4'd1;
        default: ;
      endcase
    end
  end

  assign drive     = op_write && ((state == ST_LO) || (state == ST_HI));
  assign SRAM_ADDR = {idx_q, state == ST_HI};
  assign SRAM_DQ   = drive ? ((state == ST_HI) ? wdata_q[31:16] : wdata_q[15:0]) : 16'hzzzz;
  assign SRAM_WE_N = !drive;
  assign SRAM_OE_N = drive;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

endmodule
